// File: rtl/mem_access_ctrl.sv
// Load/store initiator for a word-wide data memory.
// Sub-word stores are done as read-modify-write; load data is lane-selected and extended.
module mem_access_ctrl #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_mis_q, resp_mis_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic        req_mis;

  // Bit position of the addressed byte/half inside the memory word.
  function automatic logic [4:0] lane_shift(
    input logic [1:0] sz,
    input logic [1:0] off
  );
    logic [4:0] sh;
    sh = 5'd0;
    if (sz == 2'b00) begin
      if (BIG_ENDIAN) sh = {2'd3 - off, 3'b000};
      else            sh = {off, 3'b000};
    end else if (sz == 2'b01) begin
      sh = (off[1] ^ BIG_ENDIAN) ? 5'd16 : 5'd0;
    end
    return sh;
  endfunction

  function automatic logic [31:0] load_ext(
    input logic [31:0] rd,
    input logic [1:0]  sz,
    input logic        sg,
    input logic [1:0]  off
  );
    logic [31:0] s;
    logic [31:0] r;
    s = rd >> lane_shift(sz, off);
    unique case (sz)
      2'b00:   r = {{24{sg & s[7]}}, s[7:0]};
      2'b01:   r = {{16{sg & s[15]}}, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] rd,
    input logic [31:0] wd,
    input logic [1:0]  sz,
    input logic [1:0]  off
  );
    logic [31:0] base;
    logic [31:0] mask;
    logic [4:0]  sh;
    sh   = lane_shift(sz, off);
    base = (sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
    mask = base << sh;
    return (rd & ~mask) | ((wd & base) << sh);
  endfunction

  assign req_mis = (req_size == 2'b11)
                 | ((req_size == 2'b01) & req_addr[0])
                 | ((req_size == 2'b10) & (|req_addr[1:0]));

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_mis_d   = resp_mis_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          size_d      = req_size;
          sgn_d       = req_signed;
          off_d       = req_addr[1:0];
          wdata_d     = req_wdata;
          mem_addr_d  = {req_addr[31:2], 2'b00};
          req_ready_d = 1'b0;
          resp_mis_d  = 1'b0;
          if (req_mis) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_mis_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end else if (!req_write) begin
            state_d  = S_RD;
            mem_rd_d = 1'b1;
          end else if (req_size == 2'b10) begin
            state_d     = S_WR;
            mem_wr_d    = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d  = S_RMW_RD;
            mem_rd_d = 1'b1;
          end
        end
      end
      S_RD: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = load_ext(mem_read_data, size_q, sgn_q, off_q);
      end
      S_WR: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = 32'h0;
      end
      S_RMW_RD: begin
        state_d     = S_RMW_WR;
        mem_wr_d    = 1'b1;
        mem_wdata_d = merge(mem_read_data, wdata_q, size_q, off_q);
      end
      S_RMW_WR: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = 32'h0;
      end
      S_RESP: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        resp_mis_d  = 1'b0;
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      size_q       <= 2'b00;
      sgn_q        <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= 32'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_mis_q   <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_mis_q   <= resp_mis_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;
  assign resp_misaligned = resp_mis_q;
  assign mem_address     = mem_addr_q;
  assign mem_write_data  = mem_wdata_q;
  assign mem_read        = mem_rd_q;
  assign mem_write       = mem_wr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: word memory model plus a byte-array
// big-endian reference for load/store results.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;

  always #5 clk = ~clk;

  mem_access_ctrl #(.BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_read_data(mem_read_data)
  );

  logic [31:0] tb_mem [64];
  logic [31:0] init_word [64];
  logic        preload;

  assign mem_read_data = tb_mem[mem_address[7:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= init_word[i];
    end else if (mem_write) begin
      tb_mem[mem_address[7:2]] <= mem_write_data;
    end
  end

  logic [7:0] ref_mem [256];
  int n_checks = 0;
  int n_fail = 0;

  logic        r_resp, r_mis;
  logic [31:0] r_rdata, r_wdata;
  int          r_lat, r_nr, r_nw, r_both, r_abad;

  function automatic logic ref_mis(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] ref_word(input int wi);
    return {ref_mem[4*wi], ref_mem[4*wi+1], ref_mem[4*wi+2], ref_mem[4*wi+3]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    int i;
    logic [15:0] h;
    i = int'(a[7:0]);
    if (sz == 2'b00) return sg ? 32'(signed'(ref_mem[i])) : {24'h0, ref_mem[i]};
    h = {ref_mem[i], ref_mem[i+1]};
    if (sz == 2'b01) return sg ? 32'(signed'(h)) : {16'h0, h};
    return {ref_mem[i], ref_mem[i+1], ref_mem[i+2], ref_mem[i+3]};
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int i;
    i = int'(a[7:0]);
    if (sz == 2'b00) ref_mem[i] = wd[7:0];
    else if (sz == 2'b01) begin
      ref_mem[i] = wd[15:8]; ref_mem[i+1] = wd[7:0];
    end else begin
      ref_mem[i] = wd[31:24]; ref_mem[i+1] = wd[23:16];
      ref_mem[i+2] = wd[15:8]; ref_mem[i+3] = wd[7:0];
    end
  endtask

  task automatic wait_ready();
    for (int g = 0; g < 20 && !req_ready; g++) @(negedge clk);
  endtask

  // Issue one request and observe the transaction until its response.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    wait_ready();
    req_valid = 1'b1; req_write = w; req_size = sz;
    req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    r_resp = 0; r_mis = 0; r_rdata = 0; r_wdata = 0;
    r_lat = 0; r_nr = 0; r_nw = 0; r_both = 0; r_abad = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_read) r_nr++;
      if (mem_write) begin r_nw++; r_wdata = mem_write_data; end
      if (mem_read && mem_write) r_both++;
      if ((mem_read || mem_write) && mem_address !== {a[31:2], 2'b00}) r_abad++;
      if (resp_valid) begin
        r_resp = 1; r_lat = c; r_rdata = resp_rdata; r_mis = resp_misaligned;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; preload = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 64; i++) init_word[i] = $urandom;
    init_word[4] = 32'h8899AABB;
    for (int i = 0; i < 64; i++)
      for (int k = 0; k < 4; k++) ref_mem[4*i+k] = init_word[i][31-8*k -: 8];
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({req_ready, resp_valid, resp_misaligned, mem_read, mem_write} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_ctl: got %b expected 10000",
        {req_ready, resp_valid, resp_misaligned, mem_read, mem_write});
    end
    n_checks++;
    if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", resp_rdata); end
    n_checks++;
    if (mem_address !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", mem_address); end
    n_checks++;
    if (mem_write_data !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", mem_write_data); end
    reset = 1'b0; preload = 1'b0;
  endtask

  task automatic test_loads();
    logic [1:0]  sz [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        sg [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ad [4] = '{32'h10, 32'h13, 32'h12, 32'h10};
    logic [31:0] ex [4] = '{32'hFFFFFF88, 32'h000000BB, 32'hFFFFAABB, 32'h00008899};
    for (int i = 0; i < 4; i++) begin
      run_req(1'b0, sz[i], sg[i], ad[i], 32'h0);
      n_checks++;
      if (!r_resp || r_rdata !== ex[i]) begin
        n_fail++; $display("FAIL load%0d_rdata: got %h (resp %0b) expected %h", i, r_rdata, r_resp, ex[i]);
      end
      n_checks++;
      if (r_lat != 2 || r_nr != 1 || r_nw != 0 || r_abad != 0 || r_mis !== 1'b0) begin
        n_fail++; $display("FAIL load%0d_timing: lat %0d rd %0d wr %0d abad %0d mis %0b expected 2 1 0 0 0",
          i, r_lat, r_nr, r_nw, r_abad, r_mis);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [1:0]  sz [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] ad [3] = '{32'h12, 32'h11, 32'h10};
    for (int i = 0; i < 3; i++) begin
      run_req(i == 2, sz[i], 1'b0, ad[i], 32'hFFFF_FFFF);
      n_checks++;
      if (!r_resp || r_mis !== 1'b1 || r_lat != 1 || r_rdata !== 32'h0) begin
        n_fail++; $display("FAIL mis%0d_resp: resp %0b mis %0b lat %0d rdata %h expected 1 1 1 0",
          i, r_resp, r_mis, r_lat, r_rdata);
      end
      n_checks++;
      if (r_nr != 0 || r_nw != 0) begin
        n_fail++; $display("FAIL mis%0d_access: rd %0d wr %0d expected 0 0", i, r_nr, r_nw);
      end
    end
    n_checks++;
    if (tb_mem[4] !== 32'h8899AABB) begin
      n_fail++; $display("FAIL mis_mem: got %h expected 8899aabb", tb_mem[4]);
    end
  endtask

  task automatic test_reset_abort();
    int bad;
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01;
    req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'h0000_1234;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_read !== 1'b1) begin n_fail++; $display("FAIL abort_rmw_rd: mem_read %b expected 1", mem_read); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({req_ready, resp_valid, mem_read, mem_write} !== 4'b1000 || mem_address !== 32'h0) begin
      n_fail++; $display("FAIL abort_state: ctl %b addr %h expected 1000 0",
        {req_ready, resp_valid, mem_read, mem_write}, mem_address);
    end
    reset = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid || mem_write || mem_read) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL abort_quiet: %0d active cycles expected 0", bad); end
    n_checks++;
    if (tb_mem[4] !== 32'h8899AABB) begin
      n_fail++; $display("FAIL abort_mem: got %h expected 8899aabb", tb_mem[4]);
    end
  endtask

  task automatic test_stores();
    run_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h12345677);
    ref_store(2'b00, 32'h11, 32'h12345677);
    n_checks++;
    if (!r_resp || r_lat != 3 || r_nr != 1 || r_nw != 1 || r_rdata !== 32'h0) begin
      n_fail++; $display("FAIL sb_seq: resp %0b lat %0d rd %0d wr %0d rdata %h expected 1 3 1 1 0",
        r_resp, r_lat, r_nr, r_nw, r_rdata);
    end
    n_checks++;
    if (r_wdata !== 32'h8877AABB || r_abad != 0) begin
      n_fail++; $display("FAIL sb_wdata: got %h abad %0d expected 8877aabb", r_wdata, r_abad);
    end
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    n_checks++;
    if (r_rdata !== 32'h8877AABB) begin n_fail++; $display("FAIL sb_readback: got %h expected 8877aabb", r_rdata); end
    run_req(1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF);
    ref_store(2'b10, 32'h14, 32'hDEADBEEF);
    n_checks++;
    if (!r_resp || r_lat != 2 || r_nr != 0 || r_nw != 1 || r_rdata !== 32'h0 || r_wdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL sw_seq: lat %0d rd %0d wr %0d rdata %h wdata %h expected 2 0 1 0 deadbeef",
        r_lat, r_nr, r_nw, r_rdata, r_wdata);
    end
    run_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    n_checks++;
    if (r_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_readback: got %h expected deadbeef", r_rdata); end
  endtask

  task automatic test_back_to_back();
    logic        wr [2] = '{1'b0, 1'b1};
    logic [1:0]  sz [2] = '{2'b10, 2'b00};
    logic [31:0] ad [2] = '{32'h14, 32'h15};
    int t [3];
    int nresp, gap;
    logic [31:0] first, exp;
    for (int k = 0; k < 2; k++) begin
      exp = wr[k] ? 32'h0 : ref_load(sz[k], 1'b0, ad[k]);
      gap = (wr[k] && sz[k] != 2'b10) ? 4 : 3;
      wait_ready();
      req_valid = 1'b1; req_write = wr[k]; req_size = sz[k];
      req_signed = 1'b0; req_addr = ad[k]; req_wdata = 32'h0000_00A5;
      nresp = 0; first = 32'hX;
      for (int c = 0; c < 40 && nresp < 3; c++) begin
        @(negedge clk);
        if (resp_valid) begin
          if (nresp == 0) first = resp_rdata;
          t[nresp] = c; nresp++;
        end
      end
      req_valid = 1'b0;
      if (wr[k]) ref_store(sz[k], ad[k], 32'h0000_00A5);
      n_checks++;
      if (nresp != 3 || t[1] - t[0] != gap || t[2] - t[1] != gap) begin
        n_fail++; $display("FAIL b2b%0d_gap: resps %0d gaps %0d %0d expected 3 %0d %0d",
          k, nresp, t[1] - t[0], t[2] - t[1], gap, gap);
      end
      n_checks++;
      if (first !== exp) begin n_fail++; $display("FAIL b2b%0d_rdata: got %h expected %h", k, first, exp); end
    end
  endtask

  task automatic test_random();
    logic        w, sg, mis;
    logic [1:0]  sz;
    logic [31:0] a, wd, e_rd, e_wd;
    int e_lat, e_nr, e_nw, bad;
    for (int n = 0; n < 200; n++) begin
      w  = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      a[31:8] = 24'($urandom);
      wd = $urandom;
      mis = ref_mis(sz, a);
      e_rd = (mis || w) ? 32'h0 : ref_load(sz, sg, a);
      e_lat = mis ? 1 : (!w || sz == 2'b10) ? 2 : 3;
      e_nr = (mis || (w && sz == 2'b10)) ? 0 : 1;
      e_nw = (!mis && w) ? 1 : 0;
      if (!mis && w) ref_store(sz, a, wd);
      e_wd = ref_word(int'(a[7:2]));
      run_req(w, sz, sg, a, wd);
      n_checks++;
      if (!r_resp || r_rdata !== e_rd || r_mis !== mis) begin
        n_fail++; $display("FAIL rnd%0d_resp: resp %0b rdata %h mis %0b expected 1 %h %0b",
          n, r_resp, r_rdata, r_mis, e_rd, mis);
      end
      n_checks++;
      if (r_lat != e_lat || r_nr != e_nr || r_nw != e_nw || r_both != 0 || r_abad != 0) begin
        n_fail++; $display("FAIL rnd%0d_seq: lat %0d rd %0d wr %0d both %0d abad %0d expected %0d %0d %0d 0 0",
          n, r_lat, r_nr, r_nw, r_both, r_abad, e_lat, e_nr, e_nw);
      end
      if (e_nw == 1) begin
        n_checks++;
        if (r_wdata !== e_wd) begin
          n_fail++; $display("FAIL rnd%0d_wdata: got %h expected %h", n, r_wdata, e_wd);
        end
      end
    end
    bad = 0;
    for (int i = 0; i < 64; i++) if (tb_mem[i] !== ref_word(i)) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL rnd_memory: %0d words differ expected 0", bad); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_misaligned();
    test_reset_abort();
    test_stores();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
